camera_emulator: RTL
====================

# camera_emulator

Synthesizable transmitter side of the 8-bit parallel camera link that the camera capture path receives: it generates the camera's pixel clock, VSYNC, HREF and RGB565 byte stream from internal test patterns. It drives the same pins the physical camera drives, either on the board in loopback or in benches, so the capture and hand-tracking pipeline can be exercised without a camera. A movable colored blob lets the tracker be tested against known hand coordinates. It runs entirely in the 65 MHz pixel-clock domain.

## Interface
- H_ACTIVE, 320: active pixels per line
- V_ACTIVE, 240: active lines per frame
- H_BLANK, 144: byte slots with HREF low at the end of every line
- VSYNC_LINES, 3: lines with VSYNC high at frame start
- V_BACK, 17: blank lines after VSYNC
- V_FRONT, 10: blank lines after the active region
- BLOB_HALF, 8: blob half-width in pixels
- clk_in  input  1  65 MHz system clock
- rst_in  input  1  asynchronous, active-low reset
- enable_in  input  1  run frames; sampled at slot boundaries
- pattern_in  input  2  0 color bars, 1 solid, 2 blob, 3 ramp
- color_in  input  16  RGB565 color for solid and blob patterns
- blob_x_in  input  10  blob center x
- blob_y_in  input  9  blob center y
- cam_pclk_out  output  1  pixel clock (clk_in/2)
- cam_vsync_out  output  1  frame sync, active high
- cam_href_out  output  1  line valid, active high
- cam_data_out  output  8  data byte
- busy_out  output  1  high while a frame is in progress
- frame_done_out  output  1  one-clk_in pulse at the end of each frame

## Operation
- **Pixel clock:** cam_pclk_out toggles every clk_in cycle, free-running from reset release.
- **Slot boundary:** the clk_in edge on which cam_pclk_out goes 1→0. Every other output updates only at a slot boundary, so data is stable at each pclk rising edge.
- **Line structure:** every line is LINE_SLOTS = 2·H_ACTIVE + H_BLANK slots.
- **Frame structure:** VSYNC_LINES, then V_BACK, then V_ACTIVE, then V_FRONT lines.
- **States:** IDLE, VSYNC, VBACK, ACTIVE, VFRONT.
  - IDLE → VSYNC at a boundary where enable_in=1.
  - VSYNC, VBACK and ACTIVE each advance to the next state after their line count.
  - VFRONT → VSYNC if enable_in=1 at the final boundary, otherwise → IDLE.
  - Back-to-back frames have no gap.
- **Output levels:**
  - cam_vsync_out is high for all slots of VSYNC lines.
  - cam_href_out is high for the first 2·H_ACTIVE slots of ACTIVE lines.
  - cam_data_out carries the high byte of each pixel, then the low byte. It is 0 whenever href is low.
- **Config latch:** pattern_in, color_in, blob_x_in and blob_y_in are latched at VSYNC entry. Changes mid-frame do not take effect until the next frame.
- **Patterns** (x = pixel index in line, y = active line index):
  - Bars: bar = (x·8)/H_ACTIVE, mapped to FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - Solid: color_in.
  - Blob: color_in if |x−bx| ≤ BLOB_HALF and |y−by| ≤ BLOB_HALF, else 0000. Use signed 11-bit differences; blob clipping at edges is natural.
  - Ramp: {frame_cnt[7:0], x[7:0]}, where frame_cnt is 8 bits, wraps, and increments at each frame_done.
- **Outputs:**
  - busy_out is high from VSYNC entry until the return to IDLE.
  - frame_done_out pulses at the boundary ending the last VFRONT line.
  - Dropping enable_in mid-frame completes the current frame.
- **Reset:**
  - Outputs: rst_in low forces every output to 0 immediately, state to IDLE, and all counters and frame_cnt to 0.
  - Mid-frame reset: reset asserted mid-frame truncates the frame.
  - Resumption: the first boundary after release is the 2nd clk_in edge.

## Timing
- Latency from enable_in sampled high (IDLE, boundary) to vsync high: 0 cycles, at the same boundary.
- First href rises (VSYNC_LINES+V_BACK)·LINE_SLOTS slots after vsync rises.
- One slot is 2 clk_in cycles. One frame is (VSYNC_LINES+V_BACK+V_ACTIVE+V_FRONT)·LINE_SLOTS·2 clk_in cycles.
- The pattern generator may take one pipeline register, but the byte must be valid at its boundary.

## Configuration
- **CAMERA_EMULATOR_NOISE_EN defined:** a 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1, seed 0xACE1) steps once per pixel in ACTIVE. Its low 2 bits are XORed into pixel bits [1:0] (blue LSBs), to stress thresholding.
- **Undefined:** the LFSR is absent and pixels are exact.

## Structure
- **Package camera_emulator_pkg:**
  - state enum
  - pattern enum (PAT_BARS, PAT_SOLID, PAT_BLOB, PAT_RAMP)
  - the 8 RGB565 bar constants
  - the LFSR seed
- **Sub-module camera_emulator_pattern:**
  - Inputs: x, y, latched config, frame_cnt.
  - Output: 16-bit pixel.
- **Top:** timing counters, FSM, byte mux, pclk.

## Test plan
Bench parameters: H_ACTIVE=4, V_ACTIVE=3, H_BLANK=2, VSYNC_LINES=1, V_BACK=1, V_FRONT=1 (10-slot lines, 120 clk_in cycles per frame).
- **Reset values:** reset, release, enable_in=0 → pclk toggles; vsync, href, data, busy and frame_done stay 0 indefinitely.
- **Bars and frame timing:** enable_in=1, pattern 0.
  - vsync high 20 clk_in cycles.
  - href first rises 40 clk_in cycles after vsync rises.
  - Bytes on pclk rising edges per line: FF FF 07 FF F8 1F 00 1F.
  - frame_done pulses at 120 cycles.
- **Blob:** pattern 2, color_in=F800, BLOB_HALF=0, blob (2,1).
  - Only line 1, pixel 2 reads F8 00.
  - All other active bytes are 00.
- **Stop and back-to-back:**
  - Ramp, enable_in held high for two frames: byte pairs 00 0x in frame 0, then 01 0x in frame 1.
  - enable_in dropped mid-frame 2: the frame completes, busy falls with the frame_done pulse, then IDLE.
- **Reset mid-frame:** assert rst_in during an active line → all outputs 0 immediately; after release, the next frame starts cleanly from VSYNC.
- **Noise build:** with CAMERA_EMULATOR_NOISE_EN, solid 0000 → upper 14 bits 0, low 2 bits match the LFSR sequence from 0xACE1.

Source files
------------

// File: rtl/camera_emulator_pkg.sv
// camera_emulator_pkg: shared types and constants for the camera link emulator.
// Holds frame states, pattern codes, the colour-bar palette and the LFSR seed.
package camera_emulator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } state_e;

    typedef enum logic [1:0] {
        PAT_BARS,
        PAT_SOLID,
        PAT_BLOB,
        PAT_RAMP
    } pat_e;

    localparam logic [15:0] BAR_0 = 16'hFFFF;
    localparam logic [15:0] BAR_1 = 16'hFFE0;
    localparam logic [15:0] BAR_2 = 16'h07FF;
    localparam logic [15:0] BAR_3 = 16'h07E0;
    localparam logic [15:0] BAR_4 = 16'hF81F;
    localparam logic [15:0] BAR_5 = 16'hF800;
    localparam logic [15:0] BAR_6 = 16'h001F;
    localparam logic [15:0] BAR_7 = 16'h0000;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0: c = BAR_0;
            3'd1: c = BAR_1;
            3'd2: c = BAR_2;
            3'd3: c = BAR_3;
            3'd4: c = BAR_4;
            3'd5: c = BAR_5;
            3'd6: c = BAR_6;
            3'd7: c = BAR_7;
        endcase
        return c;
    endfunction

    // x^16+x^14+x^13+x^11+1, Fibonacci form
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

endpackage

// File: rtl/camera_emulator_pattern.sv
// camera_emulator_pattern: combinational RGB565 test-pattern generator.
// Produces the pixel at (x, y) from the per-frame latched configuration.
module camera_emulator_pattern
    import camera_emulator_pkg::*;
#(
    parameter int H_ACTIVE  = 320,
    parameter int BLOB_HALF = 8
) (
    input  logic [9:0]  x,
    input  logic [8:0]  y,
    input  logic [1:0]  pattern,
    input  logic [15:0] color,
    input  logic [9:0]  blob_x,
    input  logic [8:0]  blob_y,
    input  logic [7:0]  frame_cnt,
    output logic [15:0] pixel
);

    localparam logic signed [10:0] HALF = 11'(BLOB_HALF);

    logic [2:0]         bar_sel;
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic               in_blob;

    // bar index = floor(x*8 / H_ACTIVE), found by threshold compares
    always_comb begin
        bar_sel = '0;
        for (int b = 1; b < 8; b++) begin
            if ({x, 3'b000} >= 13'(b * H_ACTIVE)) begin
                bar_sel = 3'(b);
            end
        end
    end

    assign dx = $signed({1'b0, x}) - $signed({1'b0, blob_x});
    assign dy = $signed({2'b00, y}) - $signed({2'b00, blob_y});
    assign in_blob = (dx >= -HALF) && (dx <= HALF) &&
                     (dy >= -HALF) && (dy <= HALF);

    // pattern select
    always_comb begin
        pixel = 16'h0000;
        unique case (pat_e'(pattern))
            PAT_BARS:  pixel = bar_color(bar_sel);
            PAT_SOLID: pixel = color;
            PAT_BLOB:  pixel = in_blob ? color : 16'h0000;
            PAT_RAMP:  pixel = {frame_cnt, x[7:0]};
        endcase
    end

endmodule

// File: rtl/camera_emulator.sv
// camera_emulator: 8-bit parallel camera transmitter (pclk, vsync, href, RGB565 bytes).
// Define CAMERA_EMULATOR_NOISE_EN to XOR LFSR noise into the blue LSBs of each pixel.
module camera_emulator
    import camera_emulator_pkg::*;
#(
    parameter int H_ACTIVE    = 320,
    parameter int V_ACTIVE    = 240,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10,
    parameter int BLOB_HALF   = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        enable_in,
    input  logic [1:0]  pattern_in,
    input  logic [15:0] color_in,
    input  logic [9:0]  blob_x_in,
    input  logic [8:0]  blob_y_in,
    output logic        cam_pclk_out,
    output logic        cam_vsync_out,
    output logic        cam_href_out,
    output logic [7:0]  cam_data_out,
    output logic        busy_out,
    output logic        frame_done_out
);

    localparam int LINE_SLOTS = 2 * H_ACTIVE + H_BLANK;
    localparam int SW         = $clog2(LINE_SLOTS);
    localparam logic [SW-1:0] SLOT_LAST = SW'(LINE_SLOTS - 1);
    localparam logic [SW-1:0] HREF_END  = SW'(2 * H_ACTIVE);

    state_e        state_q;
    state_e        nxt_state;
    logic [SW-1:0] slot_q;
    logic [SW-1:0] nxt_slot;
    logic [8:0]    line_q;
    logic [8:0]    nxt_line;
    logic [8:0]    line_last;
    logic          boundary;
    logic          nxt_done;
    logic          nxt_href;
    logic          start;
    logic [1:0]    pat_q;
    logic [15:0]   color_q;
    logic [9:0]    bx_q;
    logic [8:0]    by_q;
    logic [7:0]    frame_cnt;
    logic [15:0]   pat_pix;
    logic [15:0]   pix;
    logic [7:0]    low_q;

    // the edge that drives pclk from 1 to 0 is a slot boundary
    assign boundary = cam_pclk_out;

    // free-running pixel clock at half the system clock
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) cam_pclk_out <= 1'b0;
        else         cam_pclk_out <= ~cam_pclk_out;
    end

    // last line index of the current vertical region
    always_comb begin
        line_last = '0;
        case (state_q)
            ST_VSYNC:  line_last = 9'(VSYNC_LINES - 1);
            ST_VBACK:  line_last = 9'(V_BACK - 1);
            ST_ACTIVE: line_last = 9'(V_ACTIVE - 1);
            ST_VFRONT: line_last = 9'(V_FRONT - 1);
            default:   line_last = '0;
        endcase
    end

    // position of the slot that starts at the coming boundary
    always_comb begin
        nxt_state = state_q;
        nxt_slot  = slot_q;
        nxt_line  = line_q;
        nxt_done  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (enable_in) begin
                nxt_state = ST_VSYNC;
                nxt_slot  = '0;
                nxt_line  = '0;
            end
        end else if (slot_q != SLOT_LAST) begin
            nxt_slot = slot_q + SW'(1);
        end else begin
            nxt_slot = '0;
            if (line_q != line_last) begin
                nxt_line = line_q + 9'd1;
            end else begin
                nxt_line = '0;
                case (state_q)
                    ST_VSYNC:  nxt_state = ST_VBACK;
                    ST_VBACK:  nxt_state = ST_ACTIVE;
                    ST_ACTIVE: nxt_state = ST_VFRONT;
                    ST_VFRONT: begin
                        nxt_done  = 1'b1;
                        nxt_state = enable_in ? ST_VSYNC : ST_IDLE;
                    end
                    default:   nxt_state = ST_IDLE;
                endcase
            end
        end
    end

    assign start    = (nxt_state == ST_VSYNC) &&
                      (state_q == ST_IDLE || state_q == ST_VFRONT);
    assign nxt_href = (nxt_state == ST_ACTIVE) && (nxt_slot < HREF_END);

    camera_emulator_pattern #(
        .H_ACTIVE  (H_ACTIVE),
        .BLOB_HALF (BLOB_HALF)
    ) u_pattern (
        .x         (10'(nxt_slot >> 1)),
        .y         (nxt_line),
        .pattern   (pat_q),
        .color     (color_q),
        .blob_x    (bx_q),
        .blob_y    (by_q),
        .frame_cnt (frame_cnt),
        .pixel     (pat_pix)
    );

`ifdef CAMERA_EMULATOR_NOISE_EN
    logic [15:0] lfsr_q;

    // one LFSR step per emitted pixel
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            lfsr_q <= LFSR_SEED;
        end else if (boundary && nxt_href && !nxt_slot[0]) begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

    assign pix = pat_pix ^ {14'd0, lfsr_q[1:0]};
`else
    assign pix = pat_pix;
`endif

    // frame FSM, position counters, config latch and frame counter
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= ST_IDLE;
            slot_q    <= '0;
            line_q    <= '0;
            pat_q     <= '0;
            color_q   <= '0;
            bx_q      <= '0;
            by_q      <= '0;
            frame_cnt <= '0;
        end else if (boundary) begin
            state_q <= nxt_state;
            slot_q  <= nxt_slot;
            line_q  <= nxt_line;
            if (start) begin
                pat_q   <= pattern_in;
                color_q <= color_in;
                bx_q    <= blob_x_in;
                by_q    <= blob_y_in;
            end
            if (nxt_done) frame_cnt <= frame_cnt + 8'd1;
        end
    end

    // registered link outputs, updated only at slot boundaries
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cam_vsync_out  <= 1'b0;
            cam_href_out   <= 1'b0;
            cam_data_out   <= '0;
            busy_out       <= 1'b0;
            frame_done_out <= 1'b0;
            low_q          <= '0;
        end else begin
            frame_done_out <= boundary && nxt_done;
            if (boundary) begin
                cam_vsync_out <= (nxt_state == ST_VSYNC);
                cam_href_out  <= nxt_href;
                busy_out      <= (nxt_state != ST_IDLE);
                if (!nxt_href) begin
                    cam_data_out <= '0;
                end else if (!nxt_slot[0]) begin
                    cam_data_out <= pix[15:8];
                    low_q        <= pix[7:0];
                end else begin
                    cam_data_out <= low_q;
                end
            end
        end
    end

endmodule
